iir_fold3_section: RTL

//  First-order IIR section y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1], 3-folded onto one multiplier.

---
 rtl/iir_fold3_section_if.sv | 28 ++
 rtl/iir_fold3_section.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/iir_fold3_section_if.sv
// Sample/coefficient bus for the folded first-order IIR section.
// valid/ready: a sample transfers on a rising clk edge where in_valid && in_ready;
// in_valid while in_ready is low is ignored (not queued). out_valid is a
// one-cycle pulse with no ready (the consumer cannot stall the section).
interface iir_fold3_section_if #(
    parameter int DATA_W = 20,
    parameter int COEF_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x_in;
    logic [COEF_W-1:0] b0;
    logic [COEF_W-1:0] b1;
    logic [COEF_W-1:0] a1;
    logic              out_valid;
    logic [DATA_W-1:0] y_out;
    logic [1:0]        phase;

    modport master (
        output in_valid, x_in, b0, b1, a1,
        input  in_ready, out_valid, y_out, phase
    );

    modport slave (
        input  in_valid, x_in, b0, b1, a1,
        output in_ready, out_valid, y_out, phase
    );
endinterface

// File: rtl/iir_fold3_section.sv
// First-order IIR section y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1].
// The three products share one multiplier over three clocks (MUL0..MUL2);
// the sum is rounded half-up, saturated to DATA_W and fed back as y[n-1].
module iir_fold3_section #(
    parameter int DATA_W = 20,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int ACC_W  = 40
) (
    input  logic                clk,
    input  logic                rst,
    iir_fold3_section_if.slave  bus
);
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL0 = 2'd1,
        MUL1 = 2'd2,
        MUL2 = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  x_q, x_d;
    logic signed [DATA_W-1:0]  x_d1_q, x_d1_d;
    logic signed [DATA_W-1:0]  y_d1_q, y_d1_d;
    logic signed [COEF_W-1:0]  b0_q, b0_d;
    logic signed [COEF_W-1:0]  b1_q, b1_d;
    logic signed [COEF_W-1:0]  a1_q, a1_d;
    logic signed [DATA_W-1:0]  y_out_q, y_out_d;
    logic                      out_valid_q, out_valid_d;

    logic                      accept;
    logic signed [DATA_W-1:0]  mul_x;
    logic signed [COEF_W-1:0]  mul_c;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   r_sum;
    logic signed [ACC_W-1:0]   r_rnd;
    logic signed [DATA_W-1:0]  y_sat;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_out_q;
    assign bus.phase     = state_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Shared multiplier: operand pair selected by the fold phase.
    always_comb begin
        mul_x = x_q;
        mul_c = b0_q;
        case (state_q)
            MUL1:    begin mul_x = x_d1_q; mul_c = b1_q; end
            MUL2:    begin mul_x = y_d1_q; mul_c = a1_q; end
            default: begin mul_x = x_q;    mul_c = b0_q; end
        endcase
        prod     = mul_x * mul_c;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        r_sum    = acc_q + prod_ext;
        r_rnd    = (r_sum + RND_HALF) >>> FRAC;
        if (r_rnd > SAT_MAX) begin
            y_sat = SAT_MAX[DATA_W-1:0];
        end else if (r_rnd < SAT_MIN) begin
            y_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            y_sat = r_rnd[DATA_W-1:0];
        end
    end

    // Next-state: fold sequencing, operand latching and result write-back.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        x_d         = x_q;
        x_d1_d      = x_d1_q;
        y_d1_d      = y_d1_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        a1_d        = a1_q;
        y_out_d     = y_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = $signed(bus.x_in);
                    b0_d    = $signed(bus.b0);
                    b1_d    = $signed(bus.b1);
                    a1_d    = $signed(bus.a1);
                    state_d = MUL0;
                end
            end
            MUL0: begin
                acc_d   = prod_ext;
                state_d = MUL1;
            end
            MUL1: begin
                acc_d   = r_sum;
                state_d = MUL2;
            end
            MUL2: begin
                y_out_d     = y_sat;
                y_d1_d      = y_sat;
                x_d1_d      = x_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any partial computation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            x_q         <= '0;
            x_d1_q      <= '0;
            y_d1_q      <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            a1_q        <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            x_d1_q      <= x_d1_d;
            y_d1_q      <= y_d1_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            a1_q        <= a1_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
